// File: rtl/bip_control_unit.sv
// Multi-cycle control sequencer for the BIP accumulator machine: fetch, decode,
// optional data-memory read, execute. All outputs come straight from registers.
module bip_control_unit #(
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_PC      = 11,
  parameter int NB_CYCLES  = 32
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instr,
  output logic [NB_PC-1:0]                o_pc,
  output logic                            o_instr_rd,
  output logic [NB_OPERAND-1:0]           o_operand,
  output logic                            o_rd_ram,
  output logic                            o_wr_ram,
  output logic [1:0]                      o_sel_a,
  output logic                            o_sel_b,
  output logic                            o_op,
  output logic                            o_wr_acc,
  output logic                            o_halted,
  output logic [NB_CYCLES-1:0]            o_cycles
);

  localparam int NB_INSTR = NB_OPCODE + NB_OPERAND;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  // Opcodes whose operand must first be read from data memory.
  function automatic logic needs_mem(input logic [NB_OPCODE-1:0] opc);
    logic res;
    case (opc)
      OP_LD, OP_ADD, OP_SUB: res = 1'b1;
      default:               res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic loads_acc(input logic [NB_OPCODE-1:0] opc);
    logic res;
    case (opc)
      OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

  // Returns {sel_a[1:0], sel_b, op}.
  function automatic logic [3:0] mux_sel(input logic [NB_OPCODE-1:0] opc);
    logic [3:0] res;
    case (opc)
      OP_LDI:  res = {2'd1, 1'b0, 1'b0};
      OP_ADD:  res = {2'd2, 1'b0, 1'b0};
      OP_ADDI: res = {2'd2, 1'b1, 1'b0};
      OP_SUB:  res = {2'd2, 1'b0, 1'b1};
      OP_SUBI: res = {2'd2, 1'b1, 1'b1};
      default: res = 4'd0;
    endcase
    return res;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [NB_PC-1:0]      pc_q, pc_d;
  logic [NB_INSTR-1:0]   ir_q, ir_d;
  logic [NB_CYCLES-1:0]  cycles_q, cycles_d;
  logic                  instr_rd_q, rd_ram_q, wr_ram_q, wr_acc_q, halted_q;
  logic [3:0]            sel_q;
  logic                  active_s;
  logic                  exec_d_s;
  logic [NB_OPCODE-1:0]  opc_d_s;

  assign active_s = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_MEM)   || (state_q == ST_EXEC);

  // Next-state, program counter, instruction register and cycle counter.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cycles_d = cycles_q;
    if (active_s && (cycles_q != {NB_CYCLES{1'b1}})) begin
      cycles_d = cycles_q + {{(NB_CYCLES-1){1'b0}}, 1'b1};
    end else begin
      cycles_d = cycles_q;
    end
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          state_d  = ST_FETCH;
          pc_d     = {NB_PC{1'b0}};
          ir_d     = {NB_INSTR{1'b0}};
          cycles_d = {NB_CYCLES{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d = i_instr;
        if (i_instr[NB_INSTR-1:NB_OPERAND] == OP_HLT) begin
          state_d = ST_HALT;
        end else if (needs_mem(i_instr[NB_INSTR-1:NB_OPERAND])) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + {{(NB_PC-1){1'b0}}, 1'b1};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign opc_d_s  = ir_d[NB_INSTR-1:NB_OPERAND];
  assign exec_d_s = (state_d == ST_EXEC);

  // State and registered outputs; strobes are precomputed from the next state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= {NB_PC{1'b0}};
      ir_q       <= {NB_INSTR{1'b0}};
      cycles_q   <= {NB_CYCLES{1'b0}};
      instr_rd_q <= 1'b0;
      rd_ram_q   <= 1'b0;
      wr_ram_q   <= 1'b0;
      wr_acc_q   <= 1'b0;
      halted_q   <= 1'b0;
      sel_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cycles_q   <= cycles_d;
      instr_rd_q <= (state_d == ST_FETCH);
      rd_ram_q   <= (state_d == ST_MEM);
      wr_ram_q   <= exec_d_s && (opc_d_s == OP_STO);
      wr_acc_q   <= exec_d_s && loads_acc(opc_d_s);
      halted_q   <= (state_d == ST_HALT);
      sel_q      <= mux_sel(opc_d_s);
    end
  end

  assign o_pc       = pc_q;
  assign o_instr_rd = instr_rd_q;
  assign o_operand  = ir_q[NB_OPERAND-1:0];
  assign o_rd_ram   = rd_ram_q;
  assign o_wr_ram   = wr_ram_q;
  assign o_wr_acc   = wr_acc_q;
  assign o_sel_a    = sel_q[3:2];
  assign o_sel_b    = sel_q[1];
  assign o_op       = sel_q[0];
  assign o_halted   = halted_q;
  assign o_cycles   = cycles_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench: an instruction-level model expands each program into the
// per-cycle output trace it must produce; a compare process checks every cycle.
module tb_bip_control_unit;

  typedef struct packed {
    logic [10:0] pc;
    logic        ird;
    logic [10:0] opnd;
    logic        rd;
    logic        wr;
    logic [1:0]  sa;
    logic        sb;
    logic        op;
    logic        wa;
    logic        hl;
    logic [31:0] cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr;
  logic [10:0] pc;
  logic        instr_rd, rd_ram, wr_ram, sel_b, op, wr_acc, halted;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic [31:0] cycles;

  logic [15:0] pmem [0:2047];
  rec_t        exp_q[$];
  rec_t        act;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign instr = pmem[pc];
  assign act = {pc, instr_rd, operand, rd_ram, wr_ram, sel_a, sel_b, op, wr_acc, halted, cycles};

  bip_control_unit dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_instr(instr),
    .o_pc(pc), .o_instr_rd(instr_rd), .o_operand(operand), .o_rd_ram(rd_ram),
    .o_wr_ram(wr_ram), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op),
    .o_wr_acc(wr_acc), .o_halted(halted), .o_cycles(cycles)
  );

  // Compare process: one expected record per cycle while a trace is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL trace got=%h exp=%h", act, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
    end
  endtask

  // {sel_a, sel_b, op} that the ALU-path muxes must show for an opcode.
  function automatic logic [3:0] sel_of(input logic [4:0] opc);
    case (opc)
      5'd3:    return {2'd1, 1'b0, 1'b0};
      5'd4:    return {2'd2, 1'b0, 1'b0};
      5'd5:    return {2'd2, 1'b1, 1'b0};
      5'd6:    return {2'd2, 1'b0, 1'b1};
      5'd7:    return {2'd2, 1'b1, 1'b1};
      default: return 4'd0;
    endcase
  endfunction

  function automatic rec_t mk(input logic [10:0] p, input logic [15:0] ir, input logic [31:0] c);
    rec_t r;
    r = '0;
    r.pc = p;
    r.opnd = ir[10:0];
    {r.sa, r.sb, r.op} = sel_of(ir[15:11]);
    r.cyc = c;
    return r;
  endfunction

  // Expand n instructions executed from PC 0 into the expected cycle trace.
  task automatic gen(input int n);
    logic [10:0] p = 11'd0;
    logic [15:0] ir = 16'd0;
    logic [31:0] c = 32'd0;
    logic [15:0] w;
    logic [4:0]  opc;
    rec_t        r;
    for (int k = 0; k < n; k++) begin
      w = pmem[p];
      opc = w[15:11];
      r = mk(p, ir, c); r.ird = 1'b1; exp_q.push_back(r); c++;
      r = mk(p, ir, c); exp_q.push_back(r); c++;
      ir = w;
      if (opc == 5'd0) begin
        for (int h = 0; h < 3; h++) begin
          r = mk(p, ir, c); r.hl = 1'b1; exp_q.push_back(r);
        end
        return;
      end
      if (opc == 5'd2 || opc == 5'd4 || opc == 5'd6) begin
        r = mk(p, ir, c); r.rd = 1'b1; exp_q.push_back(r); c++;
      end
      r = mk(p, ir, c);
      r.wr = (opc == 5'd1);
      r.wa = (opc >= 5'd2 && opc <= 5'd7);
      exp_q.push_back(r); c++;
      p = p + 11'd1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) pmem[i] = 16'hF800;
  endtask

  initial begin
    int n;
    fill_nop();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_outputs", {1'b0, act}, 64'd0);

    // Unknown opcode at PC 0, then HLT.
    pmem[1] = 16'h0000;
    pulse_start();
    gen(10);
    drain(50);
    chk("nop_pc", {53'd0, pc}, 64'd1);
    chk("nop_cycles", {32'd0, cycles}, 64'd5);

    // LDI 5; ADDI -1; STO 3; HLT -- restarted from HALT.
    pmem[0] = 16'h1805; pmem[1] = 16'h2FFF; pmem[2] = 16'h0803; pmem[3] = 16'h0000;
    pulse_start();
    gen(10);
    n = 1;
    while (!halted && n < 40) begin
      @(posedge clk); #1 n++;
    end
    chk("halt_rise", 64'(n), 64'd12);
    drain(20);
    chk("progA_cycles", {32'd0, cycles}, 64'd11);
    chk("progA_pc", {53'd0, pc}, 64'd3);

    // LD 10; SUB 11; HLT with a start pulse landing in the LD MEM cycle.
    pmem[0] = 16'h100A; pmem[1] = 16'h300B; pmem[2] = 16'h0000;
    pulse_start();
    gen(10);
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b1;
    chk("mem_rd_ram", {63'd0, rd_ram}, 64'd1);
    chk("mem_operand", {53'd0, operand}, 64'd10);
    @(posedge clk); #1 start = 1'b0;
    drain(40);
    chk("progB_cycles", {32'd0, cycles}, 64'd10);
    chk("progB_pc", {53'd0, pc}, 64'd2);

    // Reset asserted in the EXEC cycle of STO.
    pmem[0] = 16'h1805; pmem[1] = 16'h2FFF; pmem[2] = 16'h0803; pmem[3] = 16'h0000;
    pulse_start();
    gen(10);
    repeat (8) @(posedge clk);
    #1 chk("sto_wr_ram", {63'd0, wr_ram}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async_wr_ram", {63'd0, wr_ram}, 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 chk("post_reset_a", {1'b0, act}, 64'd0);
    @(posedge clk); #1 chk("post_reset_b", {1'b0, act}, 64'd0);

    // PC wrap: all NOPs, 2050 instructions cross 2047 -> 0.
    fill_nop();
    pulse_start();
    gen(2050);
    drain(7000);
    chk("wrap_pc", {53'd0, pc}, 64'd2);
    chk("wrap_cycles", {32'd0, cycles}, 64'd6150);
    chk("wrap_fetch", {63'd0, instr_rd}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Multi-cycle sequencer for the BIP accumulator datapath. Fetches 16-bit instructions, splits each into a 5-bit opcode and an 11-bit operand, and drives the datapath control signals. The operand feeds the 11→16 sign-extension unit and the data-memory address. Sits between program memory, data memory, the accumulator/ALU datapath and the debug unit, which reads `o_pc`, `o_halted` and `o_cycles`.

## Interface
- `NB_OPCODE`, 5, opcode field width, instruction bits [15:11].
- `NB_OPERAND`, 11, operand field width, instruction bits [10:0].
- `NB_PC`, 11, program-counter width.
- `NB_CYCLES`, 32, cycle-counter width.
- `i_clock` in 1: single clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle pulse; starts execution from PC=0.
- `i_instr` in 16: program-memory read data, valid the cycle after `o_instr_rd`.
- `o_pc` out NB_PC: program-memory address.
- `o_instr_rd` out 1: program-memory read strobe.
- `o_operand` out NB_OPERAND: IR[10:0]; goes to the sign extender and the data-memory address.
- `o_rd_ram` out 1: data-memory read strobe; data returns the next cycle.
- `o_wr_ram` out 1: data-memory write strobe; writes the accumulator to `o_operand`.
- `o_sel_a` out 2: accumulator input mux (0 = memory data, 1 = extended immediate, 2 = ALU result).
- `o_sel_b` out 1: ALU B mux (0 = memory data, 1 = extended immediate).
- `o_op` out 1: ALU operation (0 = add, 1 = sub).
- `o_wr_acc` out 1: accumulator load enable.
- `o_halted` out 1: high in HALT.
- `o_cycles` out NB_CYCLES: number of cycles spent executing.

## Operation
- FSM states and transitions:
  - IDLE → FETCH on `i_start`.
  - FETCH → DECODE.
  - DECODE → HALT, MEM or EXEC, depending on the opcode.
  - MEM → EXEC.
  - EXEC → FETCH.
  - HALT → FETCH on `i_start`.
- FETCH:
  - `o_instr_rd`=1.
- DECODE:
  - IR ← `i_instr`.
- Opcodes and their state paths:
  - 00000 HLT → HALT. PC is not incremented.
  - 00001 STO → EXEC: `o_wr_ram`=1.
  - 00010 LD → MEM → EXEC: `o_wr_acc`=1, `o_sel_a`=0.
  - 00011 LDI → EXEC: `o_wr_acc`=1, `o_sel_a`=1.
  - 00100 ADD → MEM → EXEC: `o_wr_acc`=1, `o_sel_a`=2, `o_sel_b`=0, `o_op`=0.
  - 00101 ADDI → EXEC: `o_wr_acc`=1, `o_sel_a`=2, `o_sel_b`=1, `o_op`=0.
  - 00110 SUB → same as ADD with `o_op`=1.
  - 00111 SUBI → same as ADDI with `o_op`=1.
  - Any other opcode → EXEC with every strobe at 0 (NOP).
- MEM:
  - `o_rd_ram`=1.
- EXEC:
  - Strobes as listed above.
  - PC ← PC+1 at the end of the cycle, modulo 2^NB_PC (2047 → 0).
- Strobes (`o_instr_rd`, `o_rd_ram`, `o_wr_ram`, `o_wr_acc`) are 0 in every state other than the one listed for them.
- Mux selects (`o_sel_a`, `o_sel_b`, `o_op`) are decoded from IR and held outside EXEC. This keeps them stable.
- `o_operand` = IR[10:0] at all times. It is valid and stable from DECODE+1 until the next DECODE.
- On `i_start` from IDLE or HALT:
  - PC ← 0.
  - `o_cycles` ← 0.
  - IR ← 0.
- `i_start` is ignored in FETCH, DECODE, MEM and EXEC.
- `o_cycles` increments once per cycle in FETCH, DECODE, MEM and EXEC. It saturates at all-ones and holds in IDLE and HALT.
- `o_halted`=1 only in HALT.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - state = IDLE.
  - PC = 0, IR = 0, `o_cycles` = 0.
  - Every output = 0.
- Reset mid-instruction aborts immediately, with no partial write. A strobe deasserts in the same delta as reset assertion.
- Latency per instruction, from the FETCH cycle:
  - STO, LDI, ADDI, SUBI, NOP: 3 cycles.
  - LD, ADD, SUB: 4 cycles.
  - HLT: 2 cycles, then HALT.
- Datapath timing:
  - Program memory: `i_instr` is sampled on the edge closing DECODE, one cycle after `o_instr_rd`.
  - Data memory: read data is valid in EXEC, one cycle after `o_rd_ram`.
  - Accumulator and RAM write on the edge closing EXEC.
- First FETCH is the cycle after `i_start` is sampled.

## Test plan
- Reset during EXEC of STO:
  - Required: `o_wr_ram` drops asynchronously.
  - After release: IDLE with all outputs 0, PC=0.
- Program LDI 5; ADDI -1 (operand 0x7FF); STO 3; HLT, started by `i_start`:
  - Required strobe sequence and `o_operand` values 0x005, 0x7FF, 0x003.
  - `o_halted` rises 12 cycles after `i_start`.
  - `o_cycles`=11, PC holds 3.
- LD 10; SUB 11; HLT:
  - MEM cycles assert `o_rd_ram` with `o_operand`=10, then 11.
  - LD EXEC: `o_sel_a`=0.
  - SUB EXEC: `o_sel_a`=2, `o_sel_b`=0, `o_op`=1.
  - Instruction lengths: 4, 4, 2 cycles.
- Opcode 11111 at PC 0, then HLT:
  - Required: 3-cycle NOP with no strobes, then HALT with PC=1.
- PC wrap:
  - Stimulus: from a start at PC=0, run 2047 NOPs so PC reaches 2047; the instruction at 2047 is NOP.
  - Required: PC becomes 0 and fetching continues.
- Restart and start-pulse handling:
  - `i_start` pulsed while in HALT: PC=0, `o_cycles`=0, fetch resumes.
  - `i_start` pulsed during MEM: no effect.
